// File: rtl/lcd_write_ctrl_pkg.sv
// Shared constants, state encoding and command helpers for the character-LCD write controller.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_DDRAM  = 8'h80;
  localparam logic [6:0] LCD_LINE2_ADDR = 7'h40;
  localparam logic [7:0] ASCII_LF       = 8'h0A;

  localparam int CMD_WAIT_DEFAULT   = 3;
  localparam int CLEAR_WAIT_DEFAULT = 152;
  localparam int COLS_DEFAULT       = 16;

  localparam logic [3:0] ST_WAIT_INIT  = 4'd0;
  localparam logic [3:0] ST_IDLE       = 4'd1;
  localparam logic [3:0] ST_CHAR_PULSE = 4'd2;
  localparam logic [3:0] ST_CHAR_WAIT  = 4'd3;
  localparam logic [3:0] ST_ADDR_PULSE = 4'd4;
  localparam logic [3:0] ST_ADDR_WAIT  = 4'd5;
  localparam logic [3:0] ST_CLR_PULSE  = 4'd6;
  localparam logic [3:0] ST_CLR_WAIT   = 4'd7;

  typedef enum logic [3:0] {
    S_WAIT_INIT  = ST_WAIT_INIT,
    S_IDLE       = ST_IDLE,
    S_CHAR_PULSE = ST_CHAR_PULSE,
    S_CHAR_WAIT  = ST_CHAR_WAIT,
    S_ADDR_PULSE = ST_ADDR_PULSE,
    S_ADDR_WAIT  = ST_ADDR_WAIT,
    S_CLR_PULSE  = ST_CLR_PULSE,
    S_CLR_WAIT   = ST_CLR_WAIT
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CHAR,
    CMD_ADDR,
    CMD_CLR
  } cmd_t;

  // Build a "set DDRAM address" instruction byte from a 7-bit display address.
  function automatic logic [7:0] ddram_cmd(input logic [6:0] addr);
    return LCD_CMD_DDRAM | {1'b0, addr};
  endfunction

endpackage

// File: rtl/lcd_write_ctrl_if.sv
// Character channel from the UART receive path into the LCD write controller.
interface lcd_write_ctrl_if;

  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_data,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_data,
    input  char_valid,
    output char_ready
  );

endinterface

// File: rtl/lcd_pulse_timer.sv
// One LCD bus transaction: a single-cycle E pulse, then RS/data held for wait_len+1 idle cycles.
module lcd_pulse_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] wait_len,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_byte,
  output logic       e,
  output logic       rs,
  output logic [7:0] data,
  output logic       done
);

  logic       waiting;
  logic [7:0] count;
  logic [7:0] len;

  assign done = waiting && (count == len);

  // A start on the same edge as done chains the next command with no gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e       <= 1'b0;
      rs      <= 1'b0;
      data    <= 8'h00;
      waiting <= 1'b0;
      count   <= 8'd0;
      len     <= 8'd0;
    end else if (abort) begin
      e       <= 1'b0;
      waiting <= 1'b0;
      count   <= 8'd0;
    end else if (start) begin
      e       <= 1'b1;
      rs      <= cmd_rs;
      data    <= cmd_byte;
      len     <= wait_len;
      waiting <= 1'b0;
      count   <= 8'd0;
    end else if (e) begin
      e       <= 1'b0;
      waiting <= 1'b1;
      count   <= 8'd0;
    end else if (waiting) begin
      if (count == len) begin
        waiting <= 1'b0;
        count   <= 8'd0;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/lcd_write_ctrl.sv
// Owns the LCD bus after init: writes received characters and manages the 16x2 cursor,
// line wrap, newline and full-screen clear.
module lcd_write_ctrl
  import lcd_pkg::*;
#(
  parameter int CMD_WAIT   = CMD_WAIT_DEFAULT,
  parameter int CLEAR_WAIT = CLEAR_WAIT_DEFAULT,
  parameter int COLS       = COLS_DEFAULT
) (
  input  logic                clk_1024,
  input  logic                reset_n,
  input  logic                init_complete_flag,
  input  logic                RW_init_lcd,
  input  logic                RS_init_lcd,
  input  logic [7:0]          data_init_lcd,
  input  logic                E_init_lcd,
  lcd_write_ctrl_if.slave     char_if,
  input  logic                clear_req,
  output logic                busy,
  output logic [4:0]          cursor_pos,
  output logic                RW,
  output logic                RS,
  output logic [7:0]          data,
  output logic                E
);

  localparam logic [7:0] CMD_LEN     = 8'(CMD_WAIT);
  localparam logic [7:0] CLEAR_LEN   = 8'(CLEAR_WAIT);
  localparam logic [5:0] LINE2_START = 6'(COLS);
  localparam logic [5:0] SCREEN_END  = 6'(2 * COLS);

  state_t     state;
  cmd_t       cmd;
  logic       start;
  logic       cmd_rs;
  logic [7:0] cmd_byte;
  logic [7:0] cmd_len;
  logic       timer_done;
  logic       timer_e;
  logic       timer_rs;
  logic [7:0] timer_data;
  logic [5:0] cursor_next;

  assign cursor_next = {1'b0, cursor_pos} + 6'd1;

  // Decide which command (if any) is launched on this edge; the timer and FSM both act on it.
  always_comb begin
    cmd = CMD_NONE;
    if (init_complete_flag) begin
      case (state)
        S_IDLE: begin
          if (clear_req) begin
            cmd = CMD_CLR;
          end else if (char_if.char_valid) begin
            if (char_if.char_data == ASCII_LF) begin
              cmd = ({1'b0, cursor_pos} < LINE2_START) ? CMD_ADDR : CMD_CLR;
            end else begin
              cmd = CMD_CHAR;
            end
          end
        end
        S_CHAR_WAIT: begin
          if (timer_done) begin
            if (cursor_next == LINE2_START) begin
              cmd = CMD_ADDR;
            end else if (cursor_next == SCREEN_END) begin
              cmd = CMD_CLR;
            end
          end
        end
        default: cmd = CMD_NONE;
      endcase
    end
  end

  always_comb begin
    start    = (cmd != CMD_NONE);
    cmd_rs   = 1'b0;
    cmd_byte = LCD_CMD_CLEAR;
    cmd_len  = CLEAR_LEN;
    case (cmd)
      CMD_CHAR: begin
        cmd_rs   = 1'b1;
        cmd_byte = char_if.char_data;
        cmd_len  = CMD_LEN;
      end
      CMD_ADDR: begin
        cmd_byte = ddram_cmd(LCD_LINE2_ADDR);
        cmd_len  = CMD_LEN;
      end
      default: ;
    endcase
  end

  lcd_pulse_timer u_timer (
    .clk      (clk_1024),
    .rst_n    (reset_n),
    .start    (start),
    .abort    (!init_complete_flag),
    .wait_len (cmd_len),
    .cmd_rs   (cmd_rs),
    .cmd_byte (cmd_byte),
    .e        (timer_e),
    .rs       (timer_rs),
    .data     (timer_data),
    .done     (timer_done)
  );

  // Losing init_complete_flag mid-command abandons everything and waits for a fresh init.
  always_ff @(posedge clk_1024 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_WAIT_INIT;
      cursor_pos <= 5'd0;
    end else if ((state != S_WAIT_INIT) && !init_complete_flag) begin
      state      <= S_WAIT_INIT;
      cursor_pos <= 5'd0;
    end else begin
      case (state)
        S_WAIT_INIT: begin
          if (init_complete_flag) state <= S_IDLE;
        end
        S_IDLE: begin
          case (cmd)
            CMD_CLR:  state <= S_CLR_PULSE;
            CMD_ADDR: begin
              cursor_pos <= LINE2_START[4:0];
              state      <= S_ADDR_PULSE;
            end
            CMD_CHAR: state <= S_CHAR_PULSE;
            default:  ;
          endcase
        end
        S_CHAR_PULSE: state <= S_CHAR_WAIT;
        S_CHAR_WAIT: begin
          if (timer_done) begin
            cursor_pos <= cursor_next[4:0];
            case (cmd)
              CMD_ADDR: state <= S_ADDR_PULSE;
              CMD_CLR:  state <= S_CLR_PULSE;
              default:  state <= S_IDLE;
            endcase
          end
        end
        S_ADDR_PULSE: state <= S_ADDR_WAIT;
        S_ADDR_WAIT: begin
          if (timer_done) state <= S_IDLE;
        end
        S_CLR_PULSE: state <= S_CLR_WAIT;
        S_CLR_WAIT: begin
          if (timer_done) begin
            cursor_pos <= 5'd0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_WAIT_INIT;
      endcase
    end
  end

  assign char_if.char_ready = (state == S_IDLE);
  assign busy               = (state != S_IDLE);

  assign RW   = init_complete_flag ? 1'b0       : RW_init_lcd;
  assign RS   = init_complete_flag ? timer_rs   : RS_init_lcd;
  assign data = init_complete_flag ? timer_data : data_init_lcd;
  assign E    = init_complete_flag ? timer_e    : E_init_lcd;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Randomised scoreboard bench for lcd_write_ctrl: a character-stream model predicts every LCD bus write.
module tb_lcd_write_ctrl;

  localparam int CMD_WAIT   = 3;
  localparam int CLEAR_WAIT = 152;
  localparam int COLS       = 16;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         wait_cycles;
  } write_t;

  logic       clk_1024 = 1'b0;
  logic       reset_n;
  logic       init_complete_flag;
  logic       RW_init_lcd;
  logic       RS_init_lcd;
  logic [7:0] data_init_lcd;
  logic       E_init_lcd;
  logic       clear_req;
  logic       busy;
  logic [4:0] cursor_pos;
  logic       RW;
  logic       RS;
  logic [7:0] data;
  logic       E;

  lcd_write_ctrl_if char_bus ();

  lcd_write_ctrl #(
    .CMD_WAIT   (CMD_WAIT),
    .CLEAR_WAIT (CLEAR_WAIT),
    .COLS       (COLS)
  ) dut (
    .clk_1024           (clk_1024),
    .reset_n            (reset_n),
    .init_complete_flag (init_complete_flag),
    .RW_init_lcd        (RW_init_lcd),
    .RS_init_lcd        (RS_init_lcd),
    .data_init_lcd      (data_init_lcd),
    .E_init_lcd         (E_init_lcd),
    .char_if            (char_bus.slave),
    .clear_req          (clear_req),
    .busy               (busy),
    .cursor_pos         (cursor_pos),
    .RW                 (RW),
    .RS                 (RS),
    .data               (data),
    .E                  (E)
  );

  always #5 clk_1024 = ~clk_1024;

  int     checks = 0;
  int     errors = 0;
  int     model_cursor = 0;
  write_t exp_q[$];

  bit     pending = 1'b0;
  int     gap = 0;
  int     pend_wait = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the display is 2 lines of COLS cells; a write predicts the bus commands it causes.
  function automatic void pushWrite(input logic rs, input logic [7:0] d, input int w);
    write_t item;
    item.rs          = rs;
    item.data        = d;
    item.wait_cycles = w;
    exp_q.push_back(item);
  endfunction

  function automatic void modelClear();
    pushWrite(1'b0, 8'h01, CLEAR_WAIT + 1);
    model_cursor = 0;
  endfunction

  function automatic void modelChar(input logic [7:0] ch);
    if (ch == 8'h0A) begin
      if (model_cursor < COLS) begin
        pushWrite(1'b0, 8'hC0, CMD_WAIT + 1);
        model_cursor = COLS;
      end else begin
        modelClear();
      end
    end else begin
      pushWrite(1'b1, ch, CMD_WAIT + 1);
      model_cursor++;
      if (model_cursor == COLS) pushWrite(1'b0, 8'hC0, CMD_WAIT + 1);
      else if (model_cursor == 2 * COLS) modelClear();
    end
  endfunction

  // Monitor: every E pulse after init is popped against the model, and the idle gap after it is timed.
  always @(negedge clk_1024) begin
    if (!reset_n || !init_complete_flag) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        if (E || char_bus.char_ready) begin
          checkOutput("wait_cycles", gap, pend_wait);
          pending = 1'b0;
        end else begin
          gap++;
        end
      end
      if (E) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse got rs=%0b data=%02h expected no pulse", RS, data);
        end else begin
          write_t w;
          w = exp_q.pop_front();
          checkOutput("pulse_rs", RS, w.rs);
          checkOutput("pulse_data", data, w.data);
          checkOutput("pulse_rw", RW, 1'b0);
          pending   = 1'b1;
          gap       = 0;
          pend_wait = w.wait_cycles;
        end
      end
    end
  end

  task automatic waitIdle();
    int budget = 0;
    @(negedge clk_1024);
    while (!char_bus.char_ready && budget < 400) begin
      @(negedge clk_1024);
      budget++;
    end
    checkOutput("idle_reached", char_bus.char_ready, 1);
    checkOutput("cursor_pos", cursor_pos, model_cursor);
  endtask

  // Called on a falling edge; holds char_valid until the controller accepts.
  task automatic applyStimulus(input logic [7:0] ch);
    int budget = 0;
    char_bus.char_data  = ch;
    char_bus.char_valid = 1'b1;
    while (!char_bus.char_ready && budget < 400) begin
      @(negedge clk_1024);
      budget++;
    end
    checkOutput("accept_ready", char_bus.char_ready, 1);
    if (!char_bus.char_ready) begin
      char_bus.char_valid = 1'b0;
      return;
    end
    checkOutput("cursor_before", cursor_pos, model_cursor);
    modelChar(ch);
    @(posedge clk_1024);
    @(negedge clk_1024);
    char_bus.char_valid = 1'b0;
    checkOutput("ready_after_accept", char_bus.char_ready, 0);
    waitIdle();
  endtask

  task automatic applyClear();
    clear_req = 1'b1;
    modelClear();
    @(posedge clk_1024);
    @(negedge clk_1024);
    clear_req = 1'b0;
    waitIdle();
  endtask

  task automatic checkMirror(input string name);
    checkOutput(name, {RW, RS, data, E}, {RW_init_lcd, RS_init_lcd, data_init_lcd, E_init_lcd});
  endtask

  task automatic randomInitBus();
    RW_init_lcd   = 1'($urandom_range(0, 1));
    RS_init_lcd   = 1'($urandom_range(0, 1));
    data_init_lcd = 8'($urandom_range(0, 255));
    E_init_lcd    = 1'($urandom_range(0, 1));
  endtask

  task automatic quietInitBus();
    RW_init_lcd   = 1'b0;
    RS_init_lcd   = 1'b0;
    data_init_lcd = 8'h00;
    E_init_lcd    = 1'b0;
  endtask

  initial begin
    reset_n             = 1'b0;
    init_complete_flag  = 1'b0;
    clear_req           = 1'b0;
    char_bus.char_data  = 8'h00;
    char_bus.char_valid = 1'b0;
    quietInitBus();

    #12;
    checkOutput("reset_ready", char_bus.char_ready, 0);
    checkOutput("reset_busy", busy, 1);
    checkOutput("reset_cursor", cursor_pos, 0);

    @(negedge clk_1024);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      randomInitBus();
      #1;
      checkMirror("init_mirror");
      @(negedge clk_1024);
      checkOutput("init_ready_low", char_bus.char_ready, 0);
    end
    quietInitBus();
    @(negedge clk_1024);
    init_complete_flag = 1'b1;
    @(negedge clk_1024);
    checkOutput("ready_after_init", char_bus.char_ready, 1);
    checkOutput("busy_after_init", busy, 0);

    applyStimulus(8'h41);

    // Dropping the init flag mid-write must abandon the command and clear the cursor.
    char_bus.char_data  = 8'h42;
    char_bus.char_valid = 1'b1;
    modelChar(8'h42);
    @(posedge clk_1024);
    @(negedge clk_1024);
    char_bus.char_valid = 1'b0;
    @(negedge clk_1024);
    init_complete_flag = 1'b0;
    model_cursor       = 0;
    @(negedge clk_1024);
    checkOutput("abort_busy", busy, 1);
    checkOutput("abort_ready", char_bus.char_ready, 0);
    checkOutput("abort_cursor", cursor_pos, 0);
    init_complete_flag = 1'b1;
    @(negedge clk_1024);
    checkOutput("abort_ready_again", char_bus.char_ready, 1);
    checkOutput("abort_e_low", E, 0);

    for (int i = 0; i < 2 * COLS; i++) applyStimulus(8'($urandom_range(32, 126)));

    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom_range(32, 126)));
    applyStimulus(8'h0A);
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(32, 126)));
    applyStimulus(8'h0A);

    applyStimulus(8'h43);
    clear_req           = 1'b1;
    char_bus.char_data  = 8'h5A;
    char_bus.char_valid = 1'b1;
    modelClear();
    @(posedge clk_1024);
    @(negedge clk_1024);
    clear_req = 1'b0;
    checkOutput("ready_during_clear", char_bus.char_ready, 0);
    applyStimulus(8'h5A);

    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) applyClear();
      else if (r < 3) applyStimulus(8'h0A);
      else applyStimulus(8'($urandom_range(32, 126)));
    end

    // Asynchronous reset in the middle of a clear's wait period.
    clear_req = 1'b1;
    modelClear();
    @(posedge clk_1024);
    @(negedge clk_1024);
    clear_req = 1'b0;
    repeat (51) @(negedge clk_1024);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_e", E, 0);
    checkOutput("rst_data", data, 8'h00);
    checkOutput("rst_rs", RS, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_ready", char_bus.char_ready, 0);
    checkOutput("rst_cursor", cursor_pos, 0);
    init_complete_flag = 1'b0;
    model_cursor       = 0;
    @(negedge clk_1024);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomInitBus();
      #1;
      checkMirror("post_reset_mirror");
      @(negedge clk_1024);
      checkOutput("post_reset_ready", char_bus.char_ready, 0);
    end
    quietInitBus();
    @(negedge clk_1024);
    init_complete_flag = 1'b1;
    @(negedge clk_1024);
    checkOutput("post_reset_ready_high", char_bus.char_ready, 1);
    applyStimulus(8'h51);

    repeat (3) @(negedge clk_1024);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lcd_write_ctrl.md
Name: lcd_write_ctrl

Overview:
Controller that owns the character-LCD bus after power-up initialisation. It passes the init sequencer's bus signals straight through until init_complete_flag rises. After that it accepts characters from the UART receive path over a valid/ready handshake and writes them to the display. It also manages the 16x2 cursor: line wrap, newline handling and full-screen clear.

Parameters:
CMD_WAIT, 3, wait-state count after each E pulse for normal commands/data (count runs 0..CMD_WAIT)
CLEAR_WAIT, 152, wait-state count after a clear-display command
COLS, 16, characters per display line (two lines fixed)

Ports:
clk_1024  input  1  system clock (1024 Hz tick domain)
reset_n  input  1  asynchronous active-low reset
init_complete_flag  input  1  init sequencer done; level, stays high until reset
RW_init_lcd  input  1  init sequencer RW
RS_init_lcd  input  1  init sequencer RS
data_init_lcd  input  8  init sequencer data bus
E_init_lcd  input  1  init sequencer enable
char_data  input  8  character to display (ASCII; 8'h0A = newline)
char_valid  input  1  char_data valid
char_ready  output  1  controller can accept a character this cycle
clear_req  input  1  request a display clear; sampled only in IDLE
busy  output  1  controller not in IDLE
cursor_pos  output  5  current cursor index 0..31 (0-15 line 1, 16-31 line 2)
RW  output  1  LCD RW
RS  output  1  LCD RS
data  output  8  LCD data bus
E  output  1  LCD enable

Behaviour:
- Reset (async, reset_n low): state=WAIT_INIT. Internal RW/RS/E=0, data=8'h00, count=0, cursor_pos=0. char_ready=0, busy=1.
- Bus mux (combinational): while init_complete_flag=0, RW/RS/data/E = the *_init_lcd inputs. Otherwise they are the controller's registered values.
- RW is always 0 from the controller; there are no reads and no busy-flag polling, so timing comes purely from the wait counts.
- States: WAIT_INIT, IDLE, CHAR_PULSE, CHAR_WAIT, ADDR_PULSE, ADDR_WAIT, CLR_PULSE, CLR_WAIT.
- WAIT_INIT -> IDLE on the first clock with init_complete_flag=1.
- IDLE:
  - char_ready=1 and busy=0; E=0.
  - Priority: clear_req > char_valid.
  - clear_req=1 -> CLR_PULSE.
  - Else if char_valid=1 (accept on char_valid&char_ready):
    - char_data=8'h0A -> if cursor_pos<16, set cursor_pos=16 and go to ADDR_PULSE; else go to CLR_PULSE.
    - Any other value -> latch it and go to CHAR_PULSE.
- Each PULSE state lasts 1 cycle: E=1, RS/data driven.
  - CHAR_PULSE: RS=1, data=latched character.
  - ADDR_PULSE: RS=0, data=8'hC0 (set DDRAM address 0x40).
  - CLR_PULSE: RS=0, data=8'h01.
- Each WAIT state: E=0, data/RS held. Counts 0..N (N+1 cycles), then resets count to 0.
  - N=CMD_WAIT for CHAR_WAIT and ADDR_WAIT; N=CLEAR_WAIT for CLR_WAIT.
- Total command time: CMD_WAIT+2 = 5 cycles for normal commands; CLEAR_WAIT+2 = 154 cycles for clear.
- CHAR_WAIT exit: cursor_pos increments (5-bit).
  - New value 16 -> ADDR_PULSE (auto wrap to line 2).
  - New value 32 -> CLR_PULSE.
  - Otherwise -> IDLE.
- ADDR_WAIT exit -> IDLE.
- CLR_WAIT exit -> cursor_pos=0, then IDLE.
- char_ready is low in every state except IDLE. char_valid outside IDLE is ignored; the source must hold it until accepted.
- clear_req is level-sampled in IDLE only; a pulse outside IDLE is lost.
- If init_complete_flag falls in any state other than WAIT_INIT: next clock goes to WAIT_INIT, E=0, cursor_pos=0, count=0, and the current command is aborted.
- Reset mid-command: returns to the reset state immediately, and E drops asynchronously.

Decomposition:
- Shared package lcd_pkg holds:
  - Command constants: LCD_CMD_CLEAR=8'h01, LCD_CMD_DDRAM=8'h80, LCD_LINE2_ADDR=7'h40, ASCII_LF=8'h0A.
  - State encoding localparams (4-bit).
  - Default wait counts.
- One natural sub-module, lcd_pulse_timer: given start, wait_len[7:0], rs and byte inputs, it produces the 1-cycle E pulse, the held RS/data and a done strobe. It is reused by all three command types.

Test Plan:
- Reset, then drive the *_init_lcd inputs with init_complete_flag=0 -> the bus mirrors them exactly; char_ready=0. Raise the flag -> char_ready=1 after 1 cycle.
- Send 'A' (8'h41) at cursor_pos=0 -> one cycle with E=1, RS=1, data=8'h41. Then char_ready stays low 4 more cycles, returns high, and cursor_pos=1.
- Send 16 characters -> after the 16th, an E pulse with RS=0, data=8'hC0, and cursor_pos=16. Send 16 more -> data=8'h01 pulse, 154 cycles busy, cursor_pos=0.
- Newline at cursor_pos=5 -> 8'hC0 pulse and cursor_pos=16. Newline at cursor_pos=20 -> 8'h01 pulse and cursor_pos=0.
- clear_req and char_valid asserted together in IDLE -> the clear is issued first and the character stays unaccepted (char_ready low) until the clear finishes. Then the character is written at cursor_pos=0.
- reset_n low during CLR_WAIT at count 50 -> E=0, data=8'h00, state WAIT_INIT, cursor_pos=0. After release, nothing is driven until init_complete_flag rises again.
